alu_issue_ctrl: RTL and testbench

- Initiator side of the 32-bit ripple ALU interface.
- Accepts abstract operation requests over a valid/ready handshake and encodes each one into the ALU's 4-bit ALU_control and 3-bit bonus_control.
- Holds operands stable while the combinational ALU settles, then captures result and flags.
- Returns result and flags over a valid/ready response handshake. Sits between the datapath control and the alu instance.

---
 rtl/alu_issue_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ripple ALU: encodes requests, waits SETTLE cycles, captures.
// Optional statistics counters are enabled by defining ALU_ISSUE_STAT_EN.
module alu_issue_ctrl #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned DW     = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [3:0]    req_op_i,
   input  logic [DW-1:0] req_a_i,
   input  logic [DW-1:0] req_b_i,
   output logic          alu_rst_n_o,
   output logic [DW-1:0] alu_src1_o,
   output logic [DW-1:0] alu_src2_o,
   output logic [3:0]    alu_ctrl_o,
   output logic [2:0]    alu_bonus_o,
   input  logic [DW-1:0] alu_result_i,
   input  logic          alu_zero_i,
   input  logic          alu_cout_i,
   input  logic          alu_ovf_i,
   output logic          resp_valid_o,
   input  logic          resp_ready_i,
   output logic [DW-1:0] resp_result_o,
   output logic          resp_zero_o,
   output logic          resp_cout_o,
   output logic          resp_ovf_o,
`ifdef ALU_ISSUE_STAT_EN
   input  logic          stat_clr_i,
   output logic [15:0]   op_cnt_o,
   output logic [15:0]   ovf_cnt_o,
`endif
   output logic          resp_err_o
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam logic [3:0] CtrlAdd    = 4'b0010;
   localparam logic [3:0] CtrlSub    = 4'b0110;
   localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

   // Returns {legal, ALU_control, bonus_control}.
   function automatic logic [7:0] encode_op(input logic [3:0] op);
      logic [7:0] enc;
      case (op)
         4'd0:    enc = {1'b1, 4'b0000, 3'b000};
         4'd1:    enc = {1'b1, 4'b0001, 3'b000};
         4'd2:    enc = {1'b1, 4'b0010, 3'b000};
         4'd3:    enc = {1'b1, 4'b0110, 3'b000};
         4'd4:    enc = {1'b1, 4'b1100, 3'b000};
         4'd5:    enc = {1'b1, 4'b1101, 3'b000};
         4'd6:    enc = {1'b1, 4'b0111, 3'b000};
         4'd7:    enc = {1'b1, 4'b0111, 3'b001};
         4'd8:    enc = {1'b1, 4'b0111, 3'b010};
         4'd9:    enc = {1'b1, 4'b0111, 3'b011};
         4'd10:   enc = {1'b1, 4'b0111, 3'b110};
         4'd11:   enc = {1'b1, 4'b0111, 3'b100};
         default: enc = 8'h00;
      endcase
      return enc;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic          alu_rst_n_q;
   logic [DW-1:0] src1_q, src1_d;
   logic [DW-1:0] src2_q, src2_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic [2:0]    bonus_q, bonus_d;
   logic          resp_valid_q, resp_valid_d;
   logic [DW-1:0] resp_result_q, resp_result_d;
   logic          resp_zero_q, resp_zero_d;
   logic          resp_cout_q, resp_cout_d;
   logic          resp_ovf_q, resp_ovf_d;
   logic          resp_err_q, resp_err_d;

   logic [7:0] enc;
   logic       is_add, is_sub, sub_ovf, resp_hs;

   assign enc     = encode_op(req_op_i);
   assign is_add  = (ctrl_q == CtrlAdd);
   assign is_sub  = (ctrl_q == CtrlSub);
   // The ALU's overflow output is only valid for addition.
   assign sub_ovf = (src1_q[DW-1] != src2_q[DW-1]) & (alu_result_i[DW-1] != src1_q[DW-1]);
   assign resp_hs = (state_q == StResp) & resp_ready_i;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      src1_d        = src1_q;
      src2_d        = src2_q;
      ctrl_d        = ctrl_q;
      bonus_d       = bonus_q;
      resp_valid_d  = resp_valid_q;
      resp_result_d = resp_result_q;
      resp_zero_d   = resp_zero_q;
      resp_cout_d   = resp_cout_q;
      resp_ovf_d    = resp_ovf_q;
      resp_err_d    = resp_err_q;

      case (state_q)
         StIdle: begin
            if (req_ready_q && req_valid_i) begin
               if (enc[7]) begin
                  src1_d  = req_a_i;
                  src2_d  = req_b_i;
                  ctrl_d  = enc[6:3];
                  bonus_d = enc[2:0];
                  cnt_d   = 4'd0;
                  state_d = StExec;
               end else begin
                  resp_valid_d  = 1'b1;
                  resp_result_d = '0;
                  resp_zero_d   = 1'b0;
                  resp_cout_d   = 1'b0;
                  resp_ovf_d    = 1'b0;
                  resp_err_d    = 1'b1;
                  state_d       = StResp;
               end
            end
         end
         StExec: begin
            if (cnt_q == SettleLast) begin
               resp_valid_d  = 1'b1;
               resp_result_d = alu_result_i;
               resp_zero_d   = alu_zero_i;
               resp_cout_d   = (is_add | is_sub) & alu_cout_i;
               resp_ovf_d    = is_add ? alu_ovf_i : (is_sub & sub_ovf);
               resp_err_d    = 1'b0;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StResp: begin
            if (resp_ready_i) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      req_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk_i) begin
      alu_rst_n_q <= ~rst_i;
      if (rst_i) begin
         state_q       <= StIdle;
         cnt_q         <= 4'd0;
         req_ready_q   <= 1'b0;
         src1_q        <= '0;
         src2_q        <= '0;
         ctrl_q        <= 4'd0;
         bonus_q       <= 3'd0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_zero_q   <= 1'b0;
         resp_cout_q   <= 1'b0;
         resp_ovf_q    <= 1'b0;
         resp_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         src1_q        <= src1_d;
         src2_q        <= src2_d;
         ctrl_q        <= ctrl_d;
         bonus_q       <= bonus_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_zero_q   <= resp_zero_d;
         resp_cout_q   <= resp_cout_d;
         resp_ovf_q    <= resp_ovf_d;
         resp_err_q    <= resp_err_d;
      end
   end

`ifdef ALU_ISSUE_STAT_EN
   logic [15:0] op_cnt_q, ovf_cnt_q;

   // Clear wins over increment; both saturate.
   always_ff @(posedge clk_i) begin
      if (rst_i || stat_clr_i) begin
         op_cnt_q  <= 16'd0;
         ovf_cnt_q <= 16'd0;
      end else if (resp_hs) begin
         if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
         if (resp_ovf_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
   end

   assign op_cnt_o  = op_cnt_q;
   assign ovf_cnt_o = ovf_cnt_q;
`endif

   assign req_ready_o   = req_ready_q;
   assign alu_rst_n_o   = alu_rst_n_q;
   assign alu_src1_o    = src1_q;
   assign alu_src2_o    = src2_q;
   assign alu_ctrl_o    = ctrl_q;
   assign alu_bonus_o   = bonus_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_result_o = resp_result_q;
   assign resp_zero_o   = resp_zero_q;
   assign resp_cout_o   = resp_cout_q;
   assign resp_ovf_o    = resp_ovf_q;
   assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (SETTLE=1 and SETTLE=4) driving a behavioural ALU,
// responses checked against an arithmetic reference of the opcode set.
module tb_alu_issue_ctrl;

   localparam int N = 2;
   localparam longint MaxS = 64'sd2147483647;
   localparam longint MinS = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid [N], req_ready [N], resp_valid [N], resp_ready [N], alu_rst_n [N];
   logic        resp_zero [N], resp_cout [N], resp_ovf [N], resp_err [N];
   logic        alu_zero [N], alu_cout [N], alu_ovf [N];
   logic [3:0]  req_op [N], alu_ctrl [N];
   logic [2:0]  alu_bonus [N];
   logic [31:0] req_a [N], req_b [N], alu_src1 [N], alu_src2 [N], alu_result [N];
   logic [31:0] resp_result [N];
`ifdef ALU_ISSUE_STAT_EN
   logic        stat_clr [N];
   logic [15:0] op_cnt [N], ovf_cnt [N];
   int          exp_opcnt [N];
`endif

   int checks = 0;
   int failures = 0;

   logic [3:0]  last_ctrl [N];
   logic [2:0]  last_bonus [N];
   logic [31:0] last_a [N], last_b [N];

   // {ALU_control, bonus_control} for opcodes 0..11
   logic [6:0] enc_tab [12] = '{7'b0000000, 7'b0001000, 7'b0010000, 7'b0110000,
                                7'b1100000, 7'b1101000, 7'b0111000, 7'b0111001,
                                7'b0111010, 7'b0111011, 7'b0111110, 7'b0111100};

   // Behavioural ripple ALU; its overflow is the add equation, and it emits junk flags for
   // logic/compare ops so the controller must mask them.
   function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] ctl, input logic [2:0] bon);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      c = 1'b1; v = 1'b1; r = 32'hDEADBEEF; s = '0;
      case (ctl)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b0110: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b1100: r = ~(a | b);
         4'b1101: r = ~(a & b);
         4'b0111: begin
            case (bon)
               3'b000:  r = {31'd0, $signed(a) <  $signed(b)};
               3'b001:  r = {31'd0, $signed(a) >  $signed(b)};
               3'b010:  r = {31'd0, $signed(a) <= $signed(b)};
               3'b011:  r = {31'd0, $signed(a) >= $signed(b)};
               3'b110:  r = {31'd0, a == b};
               3'b100:  r = {31'd0, a != b};
               default: r = 32'hDEADBEEF;
            endcase
         end
         default: ;
      endcase
      return {r == 32'd0, c, v, r};
   endfunction

   // Reference from the opcode definitions using plain signed/unsigned arithmetic.
   function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic z, output logic c, output logic v,
                                     output logic e);
      longint sa, sb, d;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = 1'b0; v = 1'b0; e = 1'b0; d = 0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: begin
            r = a + b; c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
            d = sa + sb; v = (d > MaxS) || (d < MinS);
         end
         4'd3: begin
            r = a - b; c = (a >= b);
            d = sa - sb; v = (d > MaxS) || (d < MinS);
         end
         4'd4:  r = ~(a | b);
         4'd5:  r = ~(a & b);
         4'd6:  r = (sa <  sb) ? 32'd1 : 32'd0;
         4'd7:  r = (sa >  sb) ? 32'd1 : 32'd0;
         4'd8:  r = (sa <= sb) ? 32'd1 : 32'd0;
         4'd9:  r = (sa >= sb) ? 32'd1 : 32'd0;
         4'd10: r = (a == b) ? 32'd1 : 32'd0;
         4'd11: r = (a != b) ? 32'd1 : 32'd0;
         default: begin r = 32'd0; e = 1'b1; end
      endcase
      z = !e && (r == 32'd0);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      alu_issue_ctrl #(.SETTLE((g == 0) ? 1 : 4), .DW(32)) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .req_valid_i  (req_valid[g]),
         .req_ready_o  (req_ready[g]),
         .req_op_i     (req_op[g]),
         .req_a_i      (req_a[g]),
         .req_b_i      (req_b[g]),
         .alu_rst_n_o  (alu_rst_n[g]),
         .alu_src1_o   (alu_src1[g]),
         .alu_src2_o   (alu_src2[g]),
         .alu_ctrl_o   (alu_ctrl[g]),
         .alu_bonus_o  (alu_bonus[g]),
         .alu_result_i (alu_result[g]),
         .alu_zero_i   (alu_zero[g]),
         .alu_cout_i   (alu_cout[g]),
         .alu_ovf_i    (alu_ovf[g]),
         .resp_valid_o (resp_valid[g]),
         .resp_ready_i (resp_ready[g]),
         .resp_result_o(resp_result[g]),
         .resp_zero_o  (resp_zero[g]),
         .resp_cout_o  (resp_cout[g]),
         .resp_ovf_o   (resp_ovf[g]),
`ifdef ALU_ISSUE_STAT_EN
         .stat_clr_i   (stat_clr[g]),
         .op_cnt_o     (op_cnt[g]),
         .ovf_cnt_o    (ovf_cnt[g]),
`endif
         .resp_err_o   (resp_err[g])
      );
      assign {alu_zero[g], alu_cout[g], alu_ovf[g], alu_result[g]} =
         alu_model(alu_src1[g], alu_src2[g], alu_ctrl[g], alu_bonus[g]);
   end

   function automatic int settle_of(input int u);
      return (u == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic clear_last();
      for (int u = 0; u < N; u++) begin
         last_ctrl[u] = 4'd0; last_bonus[u] = 3'd0; last_a[u] = 32'd0; last_b[u] = 32'd0;
`ifdef ALU_ISSUE_STAT_EN
         exp_opcnt[u] = 0;
`endif
      end
   endtask

   // Called at #1 after a rising edge; returns at #1 after the response handshake edge.
   task automatic do_op(input int u, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
      logic [31:0] er, ea, eb;
      logic        ez, ec, ev, ee;
      logic [6:0]  ectl;
      logic [35:0] eresp;
      int          k, lat;
      ref_model(op, a, b, er, ez, ec, ev, ee);
      if (!ee) begin ectl = enc_tab[op]; ea = a; eb = b; end
      else begin ectl = {last_ctrl[u], last_bonus[u]}; ea = last_a[u]; eb = last_b[u]; end
      lat   = ee ? 0 : settle_of(u);
      eresp = {er, ez, ec, ev, ee};
      k = 0;
      while (req_ready[u] !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      checks++;
      if (k >= 50) begin
         failures++; $display("FAIL ready_timeout u=%0d got=%b exp=1", u, req_ready[u]);
         return;
      end
      req_valid[u] = 1'b1; req_op[u] = op; req_a[u] = a; req_b[u] = b;
      resp_ready[u] = (stall == 0);
      @(posedge clk); #1;
      req_valid[u] = 1'b0; req_a[u] = $urandom; req_b[u] = $urandom; req_op[u] = 4'($urandom);
      k = 0;
      while (resp_valid[u] !== 1'b1 && k < 40) begin
         checks++;
         if ({alu_ctrl[u], alu_bonus[u]} !== ectl || alu_src1[u] !== ea || alu_src2[u] !== eb
             || req_ready[u] !== 1'b0) begin
            failures++;
            $display("FAIL exec_hold u=%0d op=%0d got=%b/%h/%h/%b exp=%b/%h/%h/0", u, op,
                     {alu_ctrl[u], alu_bonus[u]}, alu_src1[u], alu_src2[u], req_ready[u],
                     ectl, ea, eb);
         end
         @(posedge clk); #1; k++;
      end
      checks++;
      if (k != lat) begin
         failures++; $display("FAIL latency u=%0d op=%0d got=%0d exp=%0d", u, op, k, lat);
      end
      for (int i = 0; i <= stall; i++) begin
         checks++;
         if ({resp_result[u], resp_zero[u], resp_cout[u], resp_ovf[u], resp_err[u]} !== eresp
             || resp_valid[u] !== 1'b1 || req_ready[u] !== 1'b0
             || {alu_ctrl[u], alu_bonus[u]} !== ectl || alu_src1[u] !== ea) begin
            failures++;
            $display("FAIL resp u=%0d op=%0d a=%h b=%h cyc=%0d got=%h v=%b rdy=%b ctl=%b exp=%h ctl=%b",
                     u, op, a, b, i,
                     {resp_result[u], resp_zero[u], resp_cout[u], resp_ovf[u], resp_err[u]},
                     resp_valid[u], req_ready[u], {alu_ctrl[u], alu_bonus[u]}, eresp, ectl);
         end
         if (i < stall) begin @(posedge clk); #1; end
      end
      resp_ready[u] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 ||
          {resp_result[u], resp_zero[u], resp_cout[u], resp_ovf[u], resp_err[u]} !== eresp) begin
         failures++;
         $display("FAIL after_hs u=%0d op=%0d got=v%b r%b %h exp=v0 r1 %h", u, op,
                  resp_valid[u], req_ready[u],
                  {resp_result[u], resp_zero[u], resp_cout[u], resp_ovf[u], resp_err[u]}, eresp);
      end
      if (!ee) begin
         last_ctrl[u] = ectl[6:3]; last_bonus[u] = ectl[2:0]; last_a[u] = a; last_b[u] = b;
      end
`ifdef ALU_ISSUE_STAT_EN
      exp_opcnt[u]++;
      checks++;
      if (op_cnt[u] !== 16'(exp_opcnt[u])) begin
         failures++; $display("FAIL op_cnt u=%0d got=%0d exp=%0d", u, op_cnt[u], exp_opcnt[u]);
      end
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int u = 0; u < N; u++) begin
         checks++;
         if (req_ready[u] !== 1'b0 || alu_rst_n[u] !== 1'b0) begin
            failures++;
            $display("FAIL %s_ctl u=%0d got=rdy%b rstn%b exp=rdy0 rstn0", tag, u, req_ready[u],
                     alu_rst_n[u]);
         end
         checks++;
         if ({alu_src1[u], alu_src2[u], alu_ctrl[u], alu_bonus[u]} !== 71'd0) begin
            failures++;
            $display("FAIL %s_alu u=%0d got=%h/%h/%b/%b exp=0", tag, u, alu_src1[u],
                     alu_src2[u], alu_ctrl[u], alu_bonus[u]);
         end
         checks++;
         if ({resp_valid[u], resp_result[u], resp_zero[u], resp_cout[u], resp_ovf[u],
              resp_err[u]} !== 37'd0) begin
            failures++;
            $display("FAIL %s_resp u=%0d got=v%b %h exp=0", tag, u, resp_valid[u],
                     {resp_result[u], resp_zero[u], resp_cout[u], resp_ovf[u], resp_err[u]});
         end
`ifdef ALU_ISSUE_STAT_EN
         checks++;
         if (op_cnt[u] !== 16'd0) begin
            failures++; $display("FAIL %s_opcnt u=%0d got=%0d exp=0", tag, u, op_cnt[u]);
         end
`endif
      end
   endtask

   task automatic release_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      for (int u = 0; u < N; u++) begin
         checks++;
         if (alu_rst_n[u] !== 1'b1 || req_ready[u] !== 1'b1) begin
            failures++;
            $display("FAIL reset_release u=%0d got=rstn%b rdy%b exp=1 1", u, alu_rst_n[u],
                     req_ready[u]);
         end
      end
      clear_last();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      release_reset();
   endtask

   task automatic test_directed();
      do_op(0, 4'd2, 32'h7FFF_FFFF, 32'h1, 0);
      do_op(0, 4'd3, 32'd5, 32'd5, 0);
      do_op(0, 4'd3, 32'h8000_0000, 32'h1, 0);
      do_op(0, 4'd6, 32'hFFFF_FFFF, 32'h1, 0);
      do_op(0, 4'd9, 32'hFFFF_FFFF, 32'h1, 0);
      do_op(0, 4'd10, 32'h1234, 32'h1234, 0);
      do_op(0, 4'd13, 32'hAAAA_5555, 32'h1, 0);
      do_op(0, 4'd4, 32'hF0F0_0000, 32'h0F0F_0000, 0);
      do_op(0, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_backpressure();
      do_op(1, 4'd3, 32'h8000_0000, 32'h1, 10);
      do_op(1, 4'd2, 32'hFFFF_FFFF, 32'h1, 3);
      do_op(1, 4'd15, 32'h1, 32'h2, 5);
      do_op(1, 4'd11, 32'h7, 32'h7, 1);
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int u = 0; u < N; u++) begin
         for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'(12 + $urandom_range(0, 3))
                                              : 4'($urandom_range(0, 11));
            a  = rand_operand();
            b  = ($urandom_range(0, 3) == 0) ? a : rand_operand();
            do_op(u, op, a, b, $urandom_range(0, 3));
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc, exp_acc;
      for (int u = 0; u < N; u++) begin
         exp_acc = 30 / (settle_of(u) + 2);
         req_valid[u] = 1'b1; req_op[u] = 4'd2; req_a[u] = 32'd1; req_b[u] = 32'd2;
         resp_ready[u] = 1'b1;
         acc = 0;
         for (int i = 0; i < 30; i++) begin
            if (req_ready[u] === 1'b1) acc++;
            @(posedge clk); #1;
         end
         req_valid[u] = 1'b0;
         checks++;
         if (acc != exp_acc) begin
            failures++; $display("FAIL throughput u=%0d got=%0d exp=%0d", u, acc, exp_acc);
         end
         checks++;
         if (req_ready[u] !== 1'b1 || resp_result[u] !== 32'd3) begin
            failures++;
            $display("FAIL b2b_drain u=%0d got=rdy%b %h exp=rdy1 00000003", u, req_ready[u],
                     resp_result[u]);
         end
         last_ctrl[u] = 4'b0010; last_bonus[u] = 3'b000; last_a[u] = 32'd1; last_b[u] = 32'd2;
`ifdef ALU_ISSUE_STAT_EN
         exp_opcnt[u] += exp_acc;
`endif
      end
   endtask

   task automatic test_reset_mid();
      // Abort during EXEC on the SETTLE=4 instance.
      req_valid[1] = 1'b1; req_op[1] = 4'd3; req_a[1] = 32'd9; req_b[1] = 32'd4;
      resp_ready[1] = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_exec");
      release_reset();
      do_op(1, 4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
      // Abort during RESP with the response stalled.
      req_valid[0] = 1'b1; req_op[0] = 4'd14; resp_ready[0] = 1'b0;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_err[0] !== 1'b1) begin
         failures++;
         $display("FAIL err_resp got=v%b e%b exp=v1 e1", resp_valid[0], resp_err[0]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_resp");
      release_reset();
      do_op(0, 4'd7, 32'h5, 32'hFFFF_FFFB, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int u = 0; u < N; u++) begin
         req_valid[u] = 1'b0; req_op[u] = 4'd0; req_a[u] = 32'd0; req_b[u] = 32'd0;
         resp_ready[u] = 1'b0;
`ifdef ALU_ISSUE_STAT_EN
         stat_clr[u] = 1'b0;
`endif
      end
      clear_last();
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
